// File: rtl/pipelined_shifter_if.sv
// Operand and result valid/ready channels of pipelined_shifter.
// The master modport is the operand source and result sink; the slave modport is the shifter.
interface pipelined_shifter_if #(
    parameter int BITS = 32
);
    localparam int SHW = $clog2(BITS);

    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_data;
    logic [SHW-1:0]  in_shamt;
    logic [2:0]      in_op;

    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_data;
    logic            out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROL/ROR) with a global-stall
// valid/ready pipeline; level k is computed in stage floor(k*STAGES/L).
module pipelined_shifter #(
    parameter int BITS   = 32,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_shifter_if.slave bus
);
    localparam int L = $clog2(BITS);

    if (BITS < 4 || (BITS & (BITS - 1)) != 0 || STAGES < 1 || STAGES > L) begin : g_bad_params
        $error("pipelined_shifter: BITS must be a power of two >= 4 and 1 <= STAGES <= log2(BITS)");
    end

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    // The sign bit travels with the operand so SRA never re-reads a partial result.
    typedef struct packed {
        logic            valid;
        logic            sign;
        logic [2:0]      op;
        logic [L-1:0]    shamt;
        logic [BITS-1:0] data;
    } stage_t;

    stage_t stage_q [STAGES];
    stage_t stage_d [STAGES];
    logic   advance;

    function automatic logic [BITS-1:0] shift_level(
        input logic [BITS-1:0] x,
        input logic [2:0]      op,
        input logic            sign,
        input int              k
    );
        logic [BITS-1:0] ones;
        int              n;
        n    = 1 << k;
        ones = '1;
        case (op)
            OP_SLL:  shift_level = x << n;
            OP_SRL:  shift_level = x >> n;
            OP_SRA:  shift_level = (x >> n) | ({BITS{sign}} & ~(ones >> n));
            OP_ROL:  shift_level = (x << n) | (x >> (BITS - n));
            OP_ROR:  shift_level = (x >> n) | (x << (BITS - n));
            default: shift_level = x;
        endcase
    endfunction

    assign advance       = !stage_q[STAGES-1].valid || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = stage_q[STAGES-1].valid;
    assign bus.out_data  = stage_q[STAGES-1].data;
    assign bus.out_zero  = (stage_q[STAGES-1].data == '0);

    always_comb begin
        stage_t src;
        int     prev;
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        src  = '0;
        prev = 0;
        for (int s = 0; s < STAGES; s++) begin
            prev = (s > 0) ? s - 1 : 0;
            if (s == 0) begin
                src.valid = bus.in_valid;
                src.sign  = bus.in_data[BITS-1];
                src.op    = bus.in_op;
                src.shamt = bus.in_shamt;
                src.data  = bus.in_data;
            end else begin
                src = stage_q[prev];
            end
            for (int k = 0; k < L; k++) begin
                if ((k * STAGES) / L == s && src.shamt[k]) begin
                    src.data = shift_level(src.data, src.op, src.sign, k);
                end
            end
            stage_d[s] = src;
        end
    end

    // A low in_valid while advancing loads a bubble into stage 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
                stage_q[s] <= stage_d[s];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench: three shifters (STAGES = 1, 2, 5) share stimulus; each has a queue-based
// scoreboard fed by an arithmetic reference model of the shift/rotate rules.
module tb_pipelined_shifter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [2:0]  in_op = '0;
    logic        out_ready = 1'b1;

    logic [2:0]  rdy_w;
    logic [2:0]  vld_w;
    logic [2:0]  zero_w;
    logic [31:0] dat_w [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 5;
        pipelined_shifter_if #(.BITS(32)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data;
        assign bus.in_shamt  = in_shamt;
        assign bus.in_op     = in_op;
        assign bus.out_ready = out_ready;
        assign rdy_w[g]      = bus.in_ready;
        assign vld_w[g]      = bus.out_valid;
        assign zero_w[g]     = bus.out_zero;
        assign dat_w[g]      = bus.out_data;
        pipelined_shifter #(.BITS(32), .STAGES(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [3][$];
    logic [31:0] held [3];
    bit          was_stalled [3];
    bit          acc [3];
    int          n_out [3];
    bit          count_notready = 1'b0;
    int          n_notready_main = 0;

    function automatic int stages_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 5;
    endfunction

    // Reference: rotate by n is (x<<n)|(x>>(32-n)) computed on a 64-bit value, then truncated.
    function automatic logic [31:0] model(input logic [31:0] x, input int n, input logic [2:0] op);
        logic [63:0] w;
        w = {32'b0, x};
        case (op)
            3'd0:    return 32'(w << n);
            3'd1:    return x >> n;
            3'd2:    return 32'($signed(x) >>> n);
            3'd3:    return 32'((w << n) | (w >> (32 - n)));
            3'd4:    return 32'((w >> n) | (w << (32 - n)));
            default: return x;
        endcase
    endfunction

    task automatic check(input string tag, input int g, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[stages=%0d]: observed %h expected %h", tag, stages_of(g), obs, exp);
        end
    endtask

    // Called at the falling edge: inputs and outputs are stable for the coming rising edge.
    task automatic monitor();
        logic [31:0] e;
        for (int g = 0; g < 3; g++) begin
            check("in_ready", g, rdy_w[g], !vld_w[g] || out_ready);
            if (was_stalled[g]) begin
                check("stall_valid", g, vld_w[g], 1);
                check("stall_data", g, dat_w[g], held[g]);
            end
            if (vld_w[g] && out_ready) begin
                check("out_expected", g, exp_q[g].size() > 0, 1);
                if (exp_q[g].size() > 0) begin
                    e = exp_q[g].pop_front();
                    check("out_data", g, dat_w[g], e);
                    check("out_zero", g, zero_w[g], e == 32'd0);
                    n_out[g]++;
                end
            end
            acc[g] = in_valid && rdy_w[g];
            if (acc[g]) exp_q[g].push_back(model(in_data, int'(in_shamt), in_op));
            was_stalled[g] = vld_w[g] && !out_ready;
            held[g]        = dat_w[g];
        end
        if (count_notready && !rdy_w[1]) n_notready_main++;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] op);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_op    = op;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] op);
        set_op(d, sh, op);
        cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int g = 0; g < 3; g++) begin
            check({tag, "_out_valid"}, g, vld_w[g], 0);
            check({tag, "_out_data"}, g, dat_w[g], 0);
            check({tag, "_out_zero"}, g, zero_w[g], 1);
            check({tag, "_in_ready"}, g, rdy_w[g], 1);
        end
    endtask

    task automatic flush_model();
        for (int g = 0; g < 3; g++) begin
            exp_q[g].delete();
            was_stalled[g] = 1'b0;
        end
    endtask

    initial begin
        int first_seen [3];
        int idx;
        int base_out;

        // Reset state, then first acceptance on the first rising edge after release.
        #12;
        check_reset_outputs("reset");
        flush_model();
        @(negedge clk);
        rst_n = 1'b1;
        set_op(32'h0000_0001, 5'd31, 3'd0);
        monitor();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int g = 0; g < 3; g++) first_seen[g] = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (vld_w[g] && first_seen[g] == 0) first_seen[g] = k;
            end
            monitor();
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < 3; g++) check("latency", g, first_seen[g], stages_of(g));

        // Directed op set, back to back.
        out_ready = 1'b1;
        send(32'h8000_0000, 5'd4, 3'd2);
        send(32'h8000_0000, 5'd4, 3'd1);
        send(32'hFFFF_FFFF, 5'd31, 3'd0);
        send(32'h0000_0001, 5'd1, 3'd1);
        send(32'h0000_00F1, 5'd4, 3'd4);
        send(32'h8000_0001, 5'd1, 3'd3);
        send(32'hDEAD_BEEF, 5'd0, 3'd3);
        send(32'h1234_5678, 5'd7, 3'd5);
        send(32'h1234_5678, 5'd9, 3'd6);
        send(32'h1234_5678, 5'd31, 3'd7);
        send(32'hCAFE_F00D, 5'd0, 3'd2);
        send(32'h8765_4321, 5'd0, 3'd4);
        send(32'h8000_0000, 5'd31, 3'd2);
        send(32'h7FFF_FFFF, 5'd31, 3'd2);
        in_valid = 1'b0;
        repeat (8) cycle();

        // Eight ops, valid held high, three-cycle output stall in the middle.
        base_out        = n_out[1];
        n_notready_main = 0;
        count_notready  = 1'b1;
        idx             = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            set_op(32'h0101_0101 * (idx + 1), 5'(idx * 3 + 1), 3'(idx % 5));
            out_ready = !(c >= 4 && c <= 6);
            cycle();
            if (acc[1]) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) cycle();
        count_notready = 1'b0;
        check("stall_all_accepted", 1, idx, 8);
        check("stall_all_emitted", 1, n_out[1] - base_out, 8);
        check("stall_notready_cycles", 1, n_notready_main, 3);

        // Asynchronous reset mid-cycle with ops in flight.
        send(32'hAAAA_5555, 5'd3, 3'd3);
        send(32'h0F0F_0F0F, 5'd2, 3'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        flush_model();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) cycle();

        // Random traffic with random back-pressure.
        for (int c = 0; c < 2000; c++) begin
            set_op($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) cycle();
        for (int g = 0; g < 3; g++) check("drained", g, exp_q[g].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
